// File: rtl/gmii_rx_write_pkg.sv
// Shared GMII receive definitions: FSM states, preamble/SFD bytes and the
// FIFO word format, common to the write and read sides of the frame FIFO.
package gmii_rx_write_pkg;

  typedef enum logic [2:0] {
    IDLE_S,
    PREAMBLE_S,
    FIRST_S,
    TRANS_S,
    DISCARD_S
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Terminates a frame cut short by overflow or a receive error.
  localparam logic [8:0] TAIL_WORD = 9'h100;

  // bit8 flags the first and the last word of a frame.
  function automatic logic [8:0] mk_word(
    input logic       edge_flag,
    input logic [7:0] data
  );
    return {edge_flag, data};
  endfunction

endpackage

// File: rtl/gmii_rx_write.sv
// GMII receive front end: strips preamble/SFD, timestamps the SFD and
// writes frame bytes into a 9-bit FIFO with first/last markers.
//   i_clk, i_rst_n          : RX clock, async active-low reset
//   i_gmii_rx_dv/_rx_er/rxd : GMII receive inputs
//   iv_relative_time        : free-running time, captured at SFD
//   iv_syned_global_time    : synced global time, captured at SFD
//   ov_*_time/o_timestamp_wr: captured times and update strobe
//   ov_data/o_data_wr       : FIFO write port, i_data_full almost-full
//   o_fifo_overflow_pulse   : frame dropped/truncated by full FIFO
//   o_rx_error_pulse        : rx_er or malformed preamble
module gmii_rx_write
  import gmii_rx_write_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_gmii_rx_dv,
  input  logic        i_gmii_rx_er,
  input  logic [7:0]  iv_gmii_rxd,
  input  logic [18:0] iv_relative_time,
  input  logic [47:0] iv_syned_global_time,
  output logic [18:0] ov_relative_time,
  output logic [47:0] ov_global_time,
  output logic        o_timestamp_wr,
  output logic [8:0]  ov_data,
  output logic        o_data_wr,
  input  logic        i_data_full,
  output logic        o_fifo_overflow_pulse,
  output logic        o_rx_error_pulse
);

  rx_state_e  state_q;
  logic [7:0] hold_q;
  // Set while the held byte is the first of the frame, i.e. no word
  // of this frame has reached the FIFO yet.
  logic       first_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q               <= IDLE_S;
      hold_q                <= 8'h00;
      first_q               <= 1'b0;
      ov_relative_time      <= '0;
      ov_global_time        <= '0;
      o_timestamp_wr        <= 1'b0;
      ov_data               <= 9'h000;
      o_data_wr             <= 1'b0;
      o_fifo_overflow_pulse <= 1'b0;
      o_rx_error_pulse      <= 1'b0;
    end else begin
      o_timestamp_wr        <= 1'b0;
      o_data_wr             <= 1'b0;
      o_fifo_overflow_pulse <= 1'b0;
      o_rx_error_pulse      <= 1'b0;
      unique case (state_q)
        IDLE_S: begin
          if (i_gmii_rx_dv) begin
            if (!i_gmii_rx_er && iv_gmii_rxd == PREAMBLE_BYTE) begin
              state_q <= PREAMBLE_S;
            end else begin
              state_q          <= DISCARD_S;
              o_rx_error_pulse <= 1'b1;
            end
          end
        end
        PREAMBLE_S: begin
          if (!i_gmii_rx_dv) begin
            state_q <= IDLE_S;
          end else if (i_gmii_rx_er) begin
            state_q          <= DISCARD_S;
            o_rx_error_pulse <= 1'b1;
          end else if (iv_gmii_rxd == PREAMBLE_BYTE) begin
            state_q <= PREAMBLE_S;
          end else if (iv_gmii_rxd == SFD_BYTE) begin
            state_q          <= FIRST_S;
            ov_relative_time <= iv_relative_time;
            ov_global_time   <= iv_syned_global_time;
            o_timestamp_wr   <= 1'b1;
          end else begin
            state_q          <= DISCARD_S;
            o_rx_error_pulse <= 1'b1;
          end
        end
        FIRST_S: begin
          if (!i_gmii_rx_dv) begin
            state_q <= IDLE_S;
          end else if (i_gmii_rx_er) begin
            state_q          <= DISCARD_S;
            o_rx_error_pulse <= 1'b1;
          end else if (i_data_full) begin
            state_q               <= DISCARD_S;
            o_fifo_overflow_pulse <= 1'b1;
          end else begin
            state_q <= TRANS_S;
            hold_q  <= iv_gmii_rxd;
            first_q <= 1'b1;
          end
        end
        TRANS_S: begin
          if (!i_gmii_rx_dv) begin
            // A lone byte would make a one-word frame: drop it.
            state_q <= IDLE_S;
            if (!first_q) begin
              ov_data   <= mk_word(1'b1, hold_q);
              o_data_wr <= 1'b1;
            end
          end else if (i_gmii_rx_er) begin
            state_q          <= DISCARD_S;
            o_rx_error_pulse <= 1'b1;
            if (!first_q) begin
              ov_data   <= TAIL_WORD;
              o_data_wr <= 1'b1;
            end
          end else if (i_data_full) begin
            // Almost-full leaves room for this one closing word.
            state_q               <= DISCARD_S;
            o_fifo_overflow_pulse <= 1'b1;
            if (!first_q) begin
              ov_data   <= TAIL_WORD;
              o_data_wr <= 1'b1;
            end
          end else begin
            ov_data   <= mk_word(first_q, hold_q);
            o_data_wr <= 1'b1;
            hold_q    <= iv_gmii_rxd;
            first_q   <= 1'b0;
          end
        end
        DISCARD_S: begin
          if (!i_gmii_rx_dv) begin
            state_q <= IDLE_S;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_write.sv
// Directed testbench for gmii_rx_write: table of frame scenarios with
// hand-computed write counts, edge words and pulse counts.
module tb_gmii_rx_write;
  import gmii_rx_write_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [18:0] rel_t = 19'h00100;
  logic [47:0] glb_t = 48'h0000_1234_0000;
  logic        data_full = 1'b0;
  logic [18:0] ov_rel;
  logic [47:0] ov_glb;
  logic        ts_wr;
  logic [8:0]  ov_data;
  logic        data_wr;
  logic        ovf_p;
  logic        err_p;

  gmii_rx_write dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_gmii_rx_dv          (rx_dv),
    .i_gmii_rx_er          (rx_er),
    .iv_gmii_rxd           (rxd),
    .iv_relative_time      (rel_t),
    .iv_syned_global_time  (glb_t),
    .ov_relative_time      (ov_rel),
    .ov_global_time        (ov_glb),
    .o_timestamp_wr        (ts_wr),
    .ov_data               (ov_data),
    .o_data_wr             (data_wr),
    .i_data_full           (data_full),
    .o_fifo_overflow_pulse (ovf_p),
    .o_rx_error_pulse      (err_p)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] wr_q[$];
  int n_err, n_ovf, n_ts, bad_full;
  logic full_s;

  always @(posedge clk) begin
    full_s = data_full;
    #2;
    if (data_wr) begin
      wr_q.push_back(ov_data);
      if (full_s && ov_data !== TAIL_WORD) bad_full++;
    end
    if (err_p) n_err++;
    if (ovf_p) n_ovf++;
    if (ts_wr) n_ts++;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er,
                       input logic [7:0] d, input logic full);
    @(negedge clk);
    rx_dv = dv;
    rx_er = er;
    rxd = d;
    data_full = full;
    rel_t = rel_t + 19'd1;
    glb_t = glb_t + 48'd8;
  endtask

  typedef struct {
    string      name;
    int         pre;
    logic [7:0] sfd;
    int         len;
    int         er_at;
    int         full_at;
    int         exp_wr;
    logic [8:0] exp_first;
    logic [8:0] exp_last;
    int         exp_err;
    int         exp_ovf;
    int         exp_ts;
  } scen_t;

  scen_t tbl[12];
  logic [18:0] last_rel = '0;
  logic [47:0] last_glb = '0;

  task automatic clear_mon();
    wr_q.delete();
    n_err = 0;
    n_ovf = 0;
    n_ts = 0;
    bad_full = 0;
  endtask

  task automatic run_scn(input scen_t s);
    int mid_bad;
    clear_mon();
    for (int i = 0; i < s.pre; i++) drive(1'b1, 1'b0, PREAMBLE_BYTE, 1'b0);
    drive(1'b1, 1'b0, s.sfd, 1'b0);
    if (s.exp_ts != 0) begin
      last_rel = rel_t;
      last_glb = glb_t;
    end
    for (int i = 0; i < s.len; i++)
      drive(1'b1, (i == s.er_at), 8'(i),
            (s.full_at >= 0 && i >= s.full_at));
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk({s.name, " writes"}, 64'(wr_q.size()), 64'(s.exp_wr));
    if (s.exp_wr > 0 && wr_q.size() > 0) begin
      chk({s.name, " first"}, 64'(wr_q[0]), 64'(s.exp_first));
      chk({s.name, " last"}, 64'(wr_q[wr_q.size()-1]), 64'(s.exp_last));
    end
    mid_bad = 0;
    for (int k = 1; k < wr_q.size() - 1; k++)
      if (wr_q[k] !== {1'b0, 8'(k)}) mid_bad++;
    chk({s.name, " middle"}, 64'(mid_bad), 64'd0);
    chk({s.name, " err"}, 64'(n_err), 64'(s.exp_err));
    chk({s.name, " ovf"}, 64'(n_ovf), 64'(s.exp_ovf));
    chk({s.name, " ts_wr"}, 64'(n_ts), 64'(s.exp_ts));
    chk({s.name, " rel"}, 64'(ov_rel), 64'(last_rel));
    chk({s.name, " glb"}, 64'(ov_glb), 64'(last_glb));
    chk({s.name, " wr_full"}, 64'(bad_full), 64'd0);
    chk({s.name, " idle"}, 64'(dut.state_q), 64'(IDLE_S));
  endtask

  initial begin
    tbl[0]  = '{"long",   7, 8'hD5, 64, -1, -1, 64, 9'h100, 9'h13F, 0, 0, 1};
    tbl[1]  = '{"one",    2, 8'hD5,  1, -1, -1,  0, 9'h000, 9'h000, 0, 0, 1};
    tbl[2]  = '{"full0",  7, 8'hD5, 20, -1,  0,  0, 9'h000, 9'h000, 0, 1, 1};
    tbl[3]  = '{"after",  7, 8'hD5,  4, -1, -1,  4, 9'h100, 9'h103, 0, 0, 1};
    tbl[4]  = '{"full11", 7, 8'hD5, 30, -1, 11, 11, 9'h100, 9'h100, 0, 1, 1};
    tbl[5]  = '{"er5",    7, 8'hD5, 20,  5, -1,  5, 9'h100, 9'h100, 1, 0, 1};
    tbl[6]  = '{"badpre", 2, 8'h12,  0, -1, -1,  0, 9'h000, 9'h000, 1, 0, 0};
    tbl[7]  = '{"two",    7, 8'hD5,  2, -1, -1,  2, 9'h100, 9'h101, 0, 0, 1};
    tbl[8]  = '{"er1",    7, 8'hD5, 10,  1, -1,  0, 9'h000, 9'h000, 1, 0, 1};
    tbl[9]  = '{"er0",    7, 8'hD5, 10,  0, -1,  0, 9'h000, 9'h000, 1, 0, 1};
    tbl[10] = '{"nopre",  0, 8'hAB,  3, -1, -1,  0, 9'h000, 9'h000, 1, 0, 0};
    tbl[11] = '{"full2",  7, 8'hD5, 10, -1,  2,  2, 9'h100, 9'h100, 0, 1, 1};

    repeat (3) @(negedge clk);
    chk("reset ctl", {ts_wr, data_wr, ovf_p, err_p, ov_data}, 64'd0);
    chk("reset rel", 64'(ov_rel), 64'd0);
    chk("reset glb", 64'(ov_glb), 64'd0);
    chk("reset idle", 64'(dut.state_q), 64'(IDLE_S));
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);

    for (int t = 0; t < 12; t++) run_scn(tbl[t]);

    // Reset in the middle of a payload, released while rx_dv is still high.
    clear_mon();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, PREAMBLE_BYTE, 1'b0);
    drive(1'b1, 1'b0, SFD_BYTE, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst ctl", {ts_wr, data_wr, ovf_p, err_p, ov_data}, 64'd0);
    chk("midrst rel", 64'(ov_rel), 64'd0);
    chk("midrst glb", 64'(ov_glb), 64'd0);
    @(posedge clk);
    #2;
    chk("midrst hold", {data_wr, ov_data, dut.hold_q}, 64'd0);
    clear_mon();
    for (int i = 20; i < 26; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
    rst_n = 1'b1;
    for (int i = 26; i < 40; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst writes", 64'(wr_q.size()), 64'd0);
    chk("midrst idle", 64'(dut.state_q), 64'(IDLE_S));
    last_rel = '0;
    last_glb = '0;
    run_scn(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmii_rx_write.md
GMII_RX_WRITE -- requirements
Module: gmii_rx_write

Interface
REQ-001 i_clk  input  1  receive clock (GMII RX clock domain, 125 MHz).
REQ-002 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 i_gmii_rx_dv  input  1  GMII receive data valid.
REQ-004 i_gmii_rx_er  input  1  GMII receive error.
REQ-005 iv_gmii_rxd  input  8  GMII receive byte.
REQ-006 iv_relative_time  input  19  free-running relative time.
REQ-007 iv_syned_global_time  input  48  synchronized global time.
REQ-008 ov_relative_time  output  19  relative time captured at SFD.
REQ-009 ov_global_time  output  48  global time captured at SFD.
REQ-010 o_timestamp_wr  output  1  one-cycle pulse when ov_*_time are updated.
REQ-011 ov_data  output  9  FIFO write word; bit8=1 marks first and last byte of a frame, bits[7:0]=byte.
REQ-012 o_data_wr  output  1  FIFO write enable.
REQ-013 i_data_full  input  1  FIFO almost-full; guarantees >=2 free entries while asserted.
REQ-014 o_fifo_overflow_pulse  output  1  one-cycle pulse on frame drop or truncation due to i_data_full.
REQ-015 o_rx_error_pulse  output  1  one-cycle pulse on rx_er or bad preamble.

Function
REQ-016 States: IDLE_S, PREAMBLE_S, FIRST_S, TRANS_S, DISCARD_S; all outputs registered.
REQ-017 IDLE_S: rx_dv=1 and rxd=8'h55 -> PREAMBLE_S; rx_dv=1 with any other byte -> DISCARD_S with o_rx_error_pulse.
REQ-018 PREAMBLE_S: rxd=8'h55 -> stay; rxd=8'hD5 -> capture iv_relative_time and iv_syned_global_time, pulse o_timestamp_wr, -> FIRST_S; other byte or rx_er -> DISCARD_S with o_rx_error_pulse; rx_dv=0 -> IDLE_S silently.
REQ-019 FIRST_S: first post-SFD byte is loaded into a 1-byte hold register, nothing written; if i_data_full=1 at that cycle -> DISCARD_S with o_fifo_overflow_pulse, and no word of the frame is written.
REQ-020 FIRST_S: rx_dv=0 before any byte -> IDLE_S, nothing written.
REQ-021 Word written per byte one cycle after the following byte (or rx_dv deassertion) is sampled; first written word has bit8=1, middle words bit8=0.
REQ-022 rx_dv falls in TRANS_S: held byte written with bit8=1 -> IDLE_S.
REQ-023 Frame with exactly one post-SFD byte is discarded, nothing written.
REQ-024 i_data_full=1 sampled in TRANS_S: write {1'b1,8'h00} tail, pulse o_fifo_overflow_pulse, held byte lost, -> DISCARD_S.
REQ-025 rx_er=1 in FIRST_S/TRANS_S: if >=1 word already written, write {1'b1,8'h00} tail; pulse o_rx_error_pulse; -> DISCARD_S.
REQ-026 DISCARD_S: o_data_wr=0; rx_dv=0 -> IDLE_S.
REQ-027 Every frame in the FIFO begins and ends with bit8=1 and contains >=2 words; writes never occur while i_data_full=1 except the single tail word of REQ-024.
REQ-028 ov_*_time hold the last captured value until the next SFD.
REQ-029 No FCS check, no byte count limit.

Reset
REQ-030 On i_rst_n=0: state IDLE_S, ov_data=9'h0, o_data_wr=0, o_timestamp_wr=0, ov_relative_time=0, ov_global_time=0, both pulses 0, hold register 0.
REQ-031 Reset mid-frame: partial frame is not completed; after release, the block waits in IDLE_S/DISCARD_S for the next preamble. The FIFO is flushed by the same reset.

Structure
REQ-032 State encodings, 8'h55, 8'hD5, and the tail word {1'b1,8'h00} are placed in a shared package common with the FIFO read side.
REQ-033 Single flat module, no sub-module.

Verification
REQ-034 7x55+D5+64 bytes 00..3F -> 64 writes: first 9'h100, middle 9'h001..9'h03E, last 9'h13F; o_timestamp_wr pulses once with the values present at the D5 cycle.
REQ-035 55,55,D5,AA, then rx_dv=0 -> zero writes, state returns to IDLE_S.
REQ-036 i_data_full=1 at the first post-SFD byte -> zero writes for that frame, one overflow pulse; next frame is written normally.
REQ-037 i_data_full rises after 10 words written -> 11th write = 9'h100, one overflow pulse, no further writes until rx_dv low.
REQ-038 rx_er=1 at payload byte 5 -> tail 9'h100 written after 4 words, one o_rx_error_pulse; preamble 55,55,12 -> no writes, one error pulse.
REQ-039 i_rst_n asserted mid-payload -> all outputs 0 next cycle; after release and a fresh frame, output is identical to REQ-034.
